// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 lane demultiplexer/deserializer.
package demux_pkg;

  localparam int LANES  = 4;
  localparam int SLOT_W = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t SLOT_FIRST = 2'd0;
  localparam slot_t SLOT_LAST  = 2'd3;

endpackage

// File: rtl/demux_slot_ctr.sv
// Wrapping slot counter: advances on accepted samples, sync forces slot 0.
module demux_slot_ctr
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  adv,
  input  logic  sync,
  output slot_t slot,
  output slot_t wr_slot,
  output logic  last,
  output logic  partial
);

  // A sync sample always lands in lane 0, whatever the counter says.
  assign wr_slot = sync ? SLOT_FIRST : slot;
  assign last    = adv && !sync && (slot == SLOT_LAST);
  assign partial = sync && (slot != SLOT_FIRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= SLOT_FIRST;
    end else if (adv) begin
      slot <= wr_slot + 2'd1;
    end else if (sync) begin
      slot <= SLOT_FIRST;
    end
  end

endmodule

// File: rtl/demux4_deser.sv
// Serial-to-parallel 1:4 demultiplexer restoring mux lane order onto a
// valid/ready output register.
module demux4_deser
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [WIDTH-1:0]                  din,
  input  logic                              in_valid,
  input  logic                              sync,
  output logic [0:LANES-1][WIDTH-1:0]       dout,
  output logic                              out_valid,
  input  logic                              out_ready,
  output slot_t                             slot,
  output logic                              frame_err,
  output logic                              overrun
);

  slot_t                        wr_slot;
  logic                         last;
  logic                         partial;
  logic                         free;
  logic [WIDTH-1:0]             shadow_p0 [0:LANES-1];
  logic [0:LANES-1][WIDTH-1:0]  word_p0;

  demux_slot_ctr u_slot_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (in_valid),
    .sync    (sync),
    .slot    (slot),
    .wr_slot (wr_slot),
    .last    (last),
    .partial (partial)
  );

  // Stage p0: lane capture; the slot-3 sample bypasses the shadow.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      shadow_p0[wr_slot] <= din;
    end
  end

  assign word_p0 = {shadow_p0[0], shadow_p0[1], shadow_p0[2], din};
  assign free    = !out_valid || out_ready;

  // Stage p1: output register and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= partial;
      overrun   <= last && !free;
      if (last && free) begin
        dout      <= word_p0;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux4_deser.sv
// Directed bench for demux4_deser with a per-cycle frame-level reference model.
module tb_demux4_deser;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [0:0]      din = 1'b0;
  logic            in_valid = 1'b0;
  logic            sync = 1'b0;
  logic            out_ready = 1'b0;
  logic [0:3][0:0] dout;
  logic            out_valid;
  logic [1:0]      slot;
  logic            frame_err;
  logic            overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux4_deser #(.WIDTH(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .in_valid  (in_valid),
    .sync      (sync),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .slot      (slot),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Reference model: collects samples of the current frame by position.
  int       m_cnt;
  logic     m_buf [4];
  logic [3:0] m_dout;
  logic     m_valid, m_ferr, m_ovr;

  always @(posedge clk or negedge rst_n) begin : model
    int   idx;
    logic done;
    logic [3:0] w;
    if (!rst_n) begin
      m_cnt   <= 0;
      m_dout  <= 4'b0;
      m_valid <= 1'b0;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      done = 1'b0;
      w    = 4'b0;
      idx  = 0;
      m_ferr <= sync && (m_cnt != 0);
      if (in_valid) begin
        idx = sync ? 0 : m_cnt;
        m_buf[idx] <= din;
        done = (idx == 3);
        w = {m_buf[0], m_buf[1], m_buf[2], din};
        m_cnt <= (idx + 1) % 4;
      end else if (sync) begin
        m_cnt <= 0;
      end
      m_ovr <= done && m_valid && !out_ready;
      if (done && (!m_valid || out_ready)) begin
        m_dout  <= w;
        m_valid <= 1'b1;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_dout", {28'b0, dout}, {28'b0, m_dout});
    check("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("cyc_slot", {30'b0, slot}, m_cnt);
    check("cyc_frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
    check("cyc_overrun", {31'b0, overrun}, {31'b0, m_ovr});
  end

  task automatic cyc(input logic iv, input logic d, input logic s);
    in_valid = iv;
    din      = d;
    sync     = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sync     = 1'b0;
  endtask

  // Lane 0 is the MSB of w and is sent first.
  task automatic frame(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) cyc(1'b1, w[i], 1'b0);
  endtask

  initial begin
    logic [7:0] two;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", {28'b0, dout}, 32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_slot", {30'b0, slot}, 32'h0);
    check("rst_frame_err", {31'b0, frame_err}, 32'h0);
    check("rst_overrun", {31'b0, overrun}, 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    frame(4'b1000);
    check("f1_dout", {28'b0, dout}, 32'h8);
    check("f1_valid", {31'b0, out_valid}, 32'h1);
    check("f1_slot", {30'b0, slot}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    check("f1_valid_drop", {31'b0, out_valid}, 32'h0);

    two = 8'b1000_0110;
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b1, two[i], 1'b0);
      if (i == 4) check("b2b_dout0", {28'b0, dout}, 32'h8);
      if (i == 3) check("b2b_gap", {31'b0, out_valid}, 32'h0);
      if (i == 0) check("b2b_dout1", {28'b0, dout}, 32'h6);
    end
    cyc(1'b0, 1'b0, 1'b0);

    out_ready = 1'b0;
    frame(4'b1000);
    check("ovr_first", {28'b0, dout}, 32'h8);
    frame(4'b0001);
    check("ovr_dout_held", {28'b0, dout}, 32'h8);
    check("ovr_pulse", {31'b0, overrun}, 32'h1);
    check("ovr_valid", {31'b0, out_valid}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    check("ovr_one_shot", {31'b0, overrun}, 32'h0);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("ovr_consumed", {31'b0, out_valid}, 32'h0);

    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("ferr_pulse", {31'b0, frame_err}, 32'h1);
    check("ferr_slot", {30'b0, slot}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0);
    check("ferr_one_shot", {31'b0, frame_err}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("ferr_frame", {28'b0, dout}, 32'ha);
    check("ferr_valid", {31'b0, out_valid}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0);

    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("sync_idle_err", {31'b0, frame_err}, 32'h1);
    check("sync_idle_slot", {30'b0, slot}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0);

    out_ready = 1'b0;
    frame(4'b1100);
    check("sim_first", {31'b0, out_valid}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    out_ready = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    check("sim_valid", {31'b0, out_valid}, 32'h1);
    check("sim_dout", {28'b0, dout}, 32'h3);
    check("sim_no_ovr", {31'b0, overrun}, 32'h0);
    out_ready = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check("sim_hold", {28'b0, dout}, 32'h3);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    out_ready = 1'b0;
    frame(4'b1111);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", {28'b0, dout}, 32'h0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_slot", {30'b0, slot}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("post_rst_slot", {30'b0, slot}, 32'h0);
    check("post_rst_ferr", {31'b0, frame_err}, 32'h0);
    frame(4'b0101);
    check("post_rst_frame", {28'b0, dout}, 32'h5);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
